fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch buffer entry layout.
package cpu_pkg;
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally from storage.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];
   assign do_pop    = pop && (count_q != '0);
   // A push into a full FIFO is accepted when the head leaves in the same cycle.
   assign do_push   = push && ((count_q != FULL_CNT) || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
         if (do_push)
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
         if (do_push && !do_pop)
            count_d = count_q + CW'(1);
         else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem_q[wr_ptr_q] <= push_data;
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word requests, tracks in-flight PCs,
// drops stale responses after a redirect and buffers {PC, instr} for decode.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            jump_flag,
   input  logic [XLEN-1:0] jump_target_PC,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_PC,
   output logic [XLEN-1:0] if_instr
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned DW = 8;
   localparam int unsigned EW = $bits(fetch_entry_t);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [DW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   infl_cnt, buf_cnt;
   logic [XLEN-1:0] infl_pc;
   logic [CW:0]     occupancy;
   fetch_entry_t    buf_head, buf_entry;
   logic            req_hs, rsp_match, rsp_drop, buf_empty, buf_pop;

   // Only live (non-discarded) requests count, so a redirect can refetch at once.
   assign occupancy      = {1'b0, infl_cnt} + {1'b0, buf_cnt};
   assign imem_req_valid = rst_n && !jump_flag && (occupancy < DEPTH_W);
   assign imem_req_addr  = pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;

   assign rsp_drop  = imem_rsp_valid && (discard_q != '0);
   assign rsp_match = imem_rsp_valid && (discard_q == '0) && (infl_cnt != '0);

   assign buf_entry.pc    = infl_pc;
   assign buf_entry.instr = imem_rsp_data;
   assign buf_empty       = (buf_cnt == '0);
   assign if_valid        = !buf_empty && !jump_flag;
   assign buf_pop         = if_valid && if_ready;
   assign if_PC           = buf_empty ? '0 : buf_head.pc;
   assign if_instr        = buf_empty ? '0 : buf_head.instr;

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_inflight (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (jump_flag),
      .push      (req_hs),
      .push_data (pc_q),
      .pop       (rsp_match),
      .head_data (infl_pc),
      .count     (infl_cnt)
   );

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (jump_flag),
      .push      (rsp_match && !jump_flag),
      .push_data (buf_entry),
      .pop       (buf_pop),
      .head_data (buf_head),
      .count     (buf_cnt)
   );

   always_comb begin
      pc_d      = pc_q;
      discard_d = discard_q;
      if (rsp_drop)
         discard_d = discard_q - DW'(1);
      if (jump_flag) begin
         pc_d = jump_target_PC & ~XLEN'(3);
         // Live in-flight requests become discards; a matching response this
         // cycle is already consumed, so it is not counted twice.
         discard_d = discard_d + DW'(infl_cnt) + DW'(req_hs) - DW'(rsp_match);
      end else if (req_hs) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         discard_q <= '0;
      end else begin
         pc_q      <= pc_d;
         discard_q <= discard_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model, a program-order reference
// and a monitor that checks every instruction delivered to decode.
module tb_fetch_unit;
   localparam int unsigned DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        jump_flag, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic        if_valid, if_ready;
   logic [31:0] jump_target_PC, imem_req_addr, imem_rsp_data, if_PC, if_instr;

   logic        w_req_valid, w_rsp_valid, w_if_valid;
   logic [31:0] w_req_addr, w_rsp_data, w_if_PC, w_if_instr;

   int          n_checks = 0, n_pass = 0, cyc = 0;
   int          lat_min = 1, lat_max = 1, rdy_pct = 100, req_pct = 100, jump_pct = 0;
   int          last_due = 0;
   bit          force_jump = 1'b0, prev_jump = 1'b0;
   logic [31:0] force_tgt = '0;
   logic [31:0] exp_addr = RST_PC;
   exp_t        exp_q[$];
   mreq_t       mem_q[$];

   bit          w_hs = 1'b0;
   logic [31:0] w_addr = '0;
   int          w_idx = 0;
   logic [31:0] w_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst_n(rst_n), .jump_flag(jump_flag), .jump_target_PC(jump_target_PC),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
      .if_PC(if_PC), .if_instr(if_instr)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rst_n(rst_n), .jump_flag(1'b0), .jump_target_PC(32'h0),
      .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
      .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
      .imem_rsp_data(w_rsp_data), .if_valid(w_if_valid), .if_ready(1'b1),
      .if_PC(w_if_PC), .if_instr(w_if_instr)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] b32(input logic x);
      return {31'b0, x};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Stimulus driver and in-order memory model.
   initial begin
      jump_flag = 1'b0; jump_target_PC = '0; if_ready = 1'b0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      forever begin
         @(negedge clk);
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
         end
         if (!rst_n) begin
            jump_flag = 1'b0;
         end else if (force_jump) begin
            jump_flag      = 1'b1;
            jump_target_PC = force_tgt;
            force_jump     = 1'b0;
         end else begin
            jump_flag      = !prev_jump && (int'($urandom_range(99)) < jump_pct);
            jump_target_PC = $urandom;
         end
         prev_jump      = jump_flag;
         if_ready       = int'($urandom_range(99)) < rdy_pct;
         imem_req_ready = int'($urandom_range(99)) < req_pct;
      end
   end

   // Issue side: predicts request addresses and records expected deliveries.
   initial forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
         if (jump_flag)
            chk("req_valid_during_jump", b32(imem_req_valid), 32'd0);
         else
            chk("req_valid_occupancy", b32(imem_req_valid), b32(exp_q.size() < int'(DEPTH)));
         if (imem_req_valid && imem_req_ready && !jump_flag) begin
            int d;
            chk("req_addr", imem_req_addr, exp_addr);
            exp_q.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
            d = cyc + int'($urandom_range(lat_max - lat_min)) + lat_min;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{addr: imem_req_addr, due: d});
            exp_addr = exp_addr + 32'd4;
         end
      end
   end

   // Delivery monitor.
   initial forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
         if (jump_flag) begin
            chk("if_valid_during_jump", b32(if_valid), 32'd0);
            exp_q.delete();
            exp_addr = {jump_target_PC[31:2], 2'b00};
         end else if (if_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_instr: got pc %h, none expected (t=%0t)", if_PC, $time);
            end else begin
               chk("if_PC", if_PC, exp_q[0].pc);
               chk("if_instr", if_instr, exp_q[0].instr);
               if (if_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // Wrap instance: 1-cycle memory, always-ready decode, first three PCs checked.
   initial forever begin
      @(negedge clk);
      #3;
      w_hs   = w_req_valid;
      w_addr = w_req_addr;
      if (w_if_valid && w_idx < 3) begin
         chk("wrap_if_PC", w_if_PC, w_exp[w_idx]);
         chk("wrap_if_instr", w_if_instr, mem_word(w_exp[w_idx]));
         w_idx++;
      end
   end

   initial begin
      w_rsp_valid = 1'b0; w_rsp_data = '0;
      forever begin
         @(posedge clk);
         #1;
         w_rsp_valid = w_hs;
         w_rsp_data  = mem_word(w_addr);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      @(posedge clk);
      force_tgt  = tgt;
      force_jump = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_if_valid"}, b32(if_valid), 32'd0);
      chk({tag, "_req_valid"}, b32(imem_req_valid), 32'd0);
      chk({tag, "_if_PC"}, if_PC, 32'd0);
      chk({tag, "_if_instr"}, if_instr, 32'd0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2;
      mem_q.delete();
      exp_q.delete();
      exp_addr = RST_PC;
      last_due = cyc;
      rst_n    = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      wait_cycles(3);
      #1 check_reset_outputs("reset");
      release_reset();

      // Sequential fetch, 1-cycle memory.
      wait_cycles(8);
      // Decode stall: buffer fills, requests stop, head holds.
      rdy_pct = 0;
      wait_cycles(10);
      rdy_pct = 100;
      wait_cycles(8);
      // Redirect with two requests in flight.
      lat_min = 3; lat_max = 3;
      wait_cycles(6);
      redirect(32'h0000_0103);
      wait_cycles(12);
      // Redirect coinciding with a response on a 1-cycle memory.
      lat_min = 1; lat_max = 1;
      wait_cycles(6);
      redirect(32'h0000_0200);
      wait_cycles(8);
      // Redirect near the top of the address space to exercise PC wrap.
      redirect(32'hFFFF_FFF9);
      wait_cycles(10);

      // Randomised traffic.
      lat_min = 1; lat_max = 4; rdy_pct = 70; req_pct = 70; jump_pct = 6;
      wait_cycles(3000);

      // Reset with requests outstanding; their responses arrive during reset.
      lat_min = 3; lat_max = 3; rdy_pct = 100; req_pct = 100; jump_pct = 0;
      wait_cycles(6);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      wait_cycles(4);
      release_reset();
      wait_cycles(20);

      // Drain everything and confirm nothing was lost.
      req_pct = 0;
      wait_cycles(20);
      chk("drain_all_delivered", exp_q.size(), 32'd0);
      chk("wrap_deliveries", w_idx, 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
